// File: rtl/mips_instr_fetch.sv
`timescale 1ns/1ps
// mips_instr_fetch
//   Instruction-fetch stage of the multicycle MIPS32 CPU. Owns the PC, issues
//   32-bit word reads on an Avalon-MM master port (honouring waitrequest),
//   byte-swaps the little-endian bus word into big-endian instruction order and
//   hands it to decode over a valid/ready handshake. Accepts PC redirects from
//   execute and halts permanently on a fetch target of address 0.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   redirect_valid, redirect_pc      PC change request from execute
//   instr_valid, instr, instr_pc     fetched instruction to decode
//   instr_ready                      decode accepts the held instruction
//   active                           1 until HALT is reached
//   address, read, write, writedata,
//   byteenable, waitrequest,
//   readdata                         Avalon-MM master (read-only use)
module mips_instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter bit          BYTE_SWAP    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        active,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic [31:0] rd_swapped;
  logic [31:0] redir_tgt;
  logic [31:0] fetch_tgt;

  assign rd_swapped = BYTE_SWAP ? {readdata[7:0], readdata[15:8],
                                   readdata[23:16], readdata[31:24]}
                                : readdata;

  // Low two bits of a redirect are forced to zero: fetches are word-aligned.
  assign redir_tgt = redirect_pc & ~32'h3;

  // A redirect arriving in the completing cycle is newer than any pending one.
  assign fetch_tgt = redirect_valid ? redir_tgt : pend_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;

    unique case (state_q)
      IDLE: state_d = (pc_q == 32'h0) ? HALT : FETCH;

      FETCH: begin
        if (waitrequest) begin
          // The bus read cannot be dropped while stalled; remember the
          // redirect and squash the data once the read completes.
          if (redirect_valid) begin
            pend_d    = 1'b1;
            pend_pc_d = redir_tgt;
          end
        end else if (redirect_valid || pend_q) begin
          pc_d    = fetch_tgt;
          pend_d  = 1'b0;
          state_d = (fetch_tgt == 32'h0) ? HALT : FETCH;
        end else begin
          instr_d    = rd_swapped;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = redir_tgt;
          state_d = (redir_tgt == 32'h0) ? HALT : FETCH;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          state_d = (pc_q == 32'h0) ? HALT : FETCH;
        end
      end

      HALT: valid_d = 1'b0;

      default: state_d = IDLE;
    endcase
  end

  assign read        = (state_q == FETCH);
  assign address     = pc_q;
  assign byteenable  = read ? 4'b1111 : 4'b0000;
  assign write       = 1'b0;
  assign writedata   = '0;
  assign active      = (state_q != HALT);
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_mips_instr_fetch.sv
`timescale 1ns/1ps
module tb_mips_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        active;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  int n_chk = 0;
  int n_fail = 0;
  int n_fetch = 0;
  int wait_cycles = 0;
  int wcnt = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  mips_instr_fetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_ready(instr_ready), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .active(active),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  // Slave memory image: little-endian bus words.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h0007_1F24;
      32'hBFC0_0004: return 32'h1000_A48C;
      32'hBFC0_0100: return 32'h0000_0008;
      32'hBFC0_0104: return 32'h1111_1111;
      32'hBFC0_0200: return 32'hEFBE_ADDE;
      32'hFFFF_FFFC: return 32'h0000_000C;
      default:       return 32'h0;
    endcase
  endfunction

  assign readdata    = mem_rd(address);
  assign waitrequest = read && (wcnt < wait_cycles);

  always @(posedge clk) begin
    if (read && !waitrequest) begin
      wcnt    <= 0;
      n_fetch <= n_fetch + 1;
    end else if (read) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always begin
    @(negedge clk);
    #2;
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_instr: got %h @ %h expected none", instr, instr_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_instr", instr, mon_e.instr);
        chk("sb_instr_pc", instr_pc, mon_e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    nc(); nc();
    chk("rst_read", {31'b0, read}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_active", {31'b0, active}, 32'd1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_be", {28'b0, byteenable}, 32'h0);
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_wdata", writedata, 32'h0);
    rst = 1'b0;

    // T1: zero-wait fetch from the reset vector
    nc();
    chk("t1_read", {31'b0, read}, 32'd1);
    chk("t1_addr", address, 32'hBFC0_0000);
    chk("t1_be", {28'b0, byteenable}, 32'hF);
    sb.push_back('{instr: 32'h241F_0700, pc: 32'hBFC0_0000});
    nc();
    chk("t1_valid", {31'b0, instr_valid}, 32'd1);
    chk("t1_instr", instr, 32'h241F_0700);
    chk("t1_instr_pc", instr_pc, 32'hBFC0_0000);
    chk("t1_read_gap", {31'b0, read}, 32'd0);
    chk("t1_next_addr", address, 32'hBFC0_0004);
    instr_ready = 1'b1; wait_cycles = 3;
    sb.push_back('{instr: 32'h8CA4_0010, pc: 32'hBFC0_0004});

    // T2: three wait states, then hold without ready
    nc();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_read", {31'b0, read}, 32'd1);
      chk("t2_stall_addr", address, 32'hBFC0_0004);
      chk("t2_stall_wait", {31'b0, waitrequest}, 32'd1);
      chk("t2_stall_valid", {31'b0, instr_valid}, 32'd0);
      nc();
    end
    chk("t2_wait_drop", {31'b0, waitrequest}, 32'd0);
    chk("t2_read_last", {31'b0, read}, 32'd1);
    nc();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("t2_hold_instr", instr, 32'h8CA4_0010);
      chk("t2_hold_read", {31'b0, read}, 32'd0);
      nc();
    end
    chk("t2_fetch_count", 32'(n_fetch), 32'd2);

    // T3: redirect while holding, with ready
    redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0100; instr_ready = 1'b1; wait_cycles = 0;
    nc();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    chk("t3_read", {31'b0, read}, 32'd1);
    chk("t3_addr", address, 32'hBFC0_0100);
    chk("t3_valid", {31'b0, instr_valid}, 32'd0);
    sb.push_back('{instr: 32'h0800_0000, pc: 32'hBFC0_0100});
    nc();
    chk("t3_cap_valid", {31'b0, instr_valid}, 32'd1);
    chk("t3_cap_pc", instr_pc, 32'hBFC0_0100);
    instr_ready = 1'b1; wait_cycles = 3;

    // T4: redirect during a stalled read; the read completes and is dropped
    nc();
    instr_ready = 1'b0;
    chk("t4_read", {31'b0, read}, 32'd1);
    chk("t4_addr", address, 32'hBFC0_0104);
    chk("t4_wait", {31'b0, waitrequest}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0200;
    nc();
    redirect_valid = 1'b0;
    chk("t4_hold_addr", address, 32'hBFC0_0104);
    chk("t4_valid_a", {31'b0, instr_valid}, 32'd0);
    nc();
    chk("t4_hold_addr2", address, 32'hBFC0_0104);
    chk("t4_valid_b", {31'b0, instr_valid}, 32'd0);
    nc();
    chk("t4_done_wait", {31'b0, waitrequest}, 32'd0);
    chk("t4_done_read", {31'b0, read}, 32'd1);
    chk("t4_done_addr", address, 32'hBFC0_0104);
    wait_cycles = 0;
    sb.push_back('{instr: 32'hDEAD_BEEF, pc: 32'hBFC0_0200});
    nc();
    chk("t4_new_read", {31'b0, read}, 32'd1);
    chk("t4_new_addr", address, 32'hBFC0_0200);
    chk("t4_discard_valid", {31'b0, instr_valid}, 32'd0);
    nc();
    chk("t4_cap_valid", {31'b0, instr_valid}, 32'd1);
    chk("t4_cap_instr", instr, 32'hDEAD_BEEF);
    instr_ready = 1'b1;

    // T5: redirect to 0 halts for good
    nc();
    instr_ready = 1'b0;
    chk("t5_addr", address, 32'hBFC0_0204);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    nc();
    chk("t5_active", {31'b0, active}, 32'd0);
    chk("t5_read", {31'b0, read}, 32'd0);
    chk("t5_valid", {31'b0, instr_valid}, 32'd0);
    redirect_pc = 32'hBFC0_0300; instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nc();
      chk("t5_halt_active", {31'b0, active}, 32'd0);
      chk("t5_halt_read", {31'b0, read}, 32'd0);
      chk("t5_halt_be", {28'b0, byteenable}, 32'h0);
    end

    // T6: reset in the middle of a stalled read
    redirect_valid = 1'b0; instr_ready = 1'b0; rst = 1'b1;
    nc();
    rst = 1'b0; wait_cycles = 5;
    nc();
    chk("t6_read", {31'b0, read}, 32'd1);
    chk("t6_addr", address, 32'hBFC0_0000);
    chk("t6_wait", {31'b0, waitrequest}, 32'd1);
    rst = 1'b1;
    nc();
    chk("t6_rst_read", {31'b0, read}, 32'd0);
    chk("t6_rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("t6_rst_active", {31'b0, active}, 32'd1);
    rst = 1'b0; wait_cycles = 0;
    nc();
    chk("t6_refetch_addr", address, 32'hBFC0_0000);
    chk("t6_refetch_read", {31'b0, read}, 32'd1);
    sb.push_back('{instr: 32'h241F_0700, pc: 32'hBFC0_0000});
    nc();
    chk("t6_cap_valid", {31'b0, instr_valid}, 32'd1);
    chk("t6_fetch_count", 32'(n_fetch), 32'd7);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    nc();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    chk("t6_top_addr", address, 32'hFFFF_FFFC);
    chk("t6_top_read", {31'b0, read}, 32'd1);
    sb.push_back('{instr: 32'h0C00_0000, pc: 32'hFFFF_FFFC});
    nc();
    chk("t6_top_valid", {31'b0, instr_valid}, 32'd1);
    chk("t6_wrap_pc", address, 32'h0);
    chk("t6_top_instr", instr, 32'h0C00_0000);
    instr_ready = 1'b1;
    nc();
    instr_ready = 1'b0;
    chk("t6_halt_active", {31'b0, active}, 32'd0);
    chk("t6_halt_read", {31'b0, read}, 32'd0);
    chk("t6_halt_valid", {31'b0, instr_valid}, 32'd0);
    nc(); nc();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
